// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: sequential AES-128 key-schedule controller.
// Emits round keys rk0..rkNUM_ROUNDS one at a time on a valid/ready port.
// SubWord is computed by an external 4-byte S-box unit: one word per round
// goes out on sub_word_out and the result returns on sub_word_in in the same cycle.
// Optional build macro KEY_EXPAND_ABORT_EN adds an 'abort' input that
// forces the controller back to IDLE from any busy state.
module key_expand_ctrl #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         start,
`ifdef KEY_EXPAND_ABORT_EN
  input  logic         abort,
`endif
  output logic         ready_out,
  output logic [31:0]  sub_word_out,
  output logic [3:0]   sub_round_out,
  input  logic [31:0]  sub_word_in,
  input  logic [3:0]   sub_round_in,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last,
  output logic         tag_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EMIT = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] MIX  = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  logic [1:0]   state;
  logic [127:0] key_q;
  logic [31:0]  temp_q;
  logic [3:0]   idx_q;
  logic [7:0]   rcon_q;
  logic         tag_err_q;
  logic [31:0]  sub_word_q;
  logic [3:0]   sub_round_q;
  logic         abort_req;
  logic         rk_hs;
  logic         idx_last;
  logic [127:0] key_mix;

  // GF(2^8) multiply-by-x used to step the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // RotWord: rotate a word left by one byte.
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

`ifdef KEY_EXPAND_ABORT_EN
  assign abort_req = abort & (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  assign rk_hs         = (state == EMIT) & rk_ready;
  assign idx_last      = (idx_q == LAST_IDX);
  assign ready_out     = (state == IDLE);
  assign rk_valid      = (state == EMIT);
  assign rk_out        = key_q;
  assign rk_idx        = idx_q;
  assign rk_last       = rk_valid & idx_last;
  assign tag_err       = tag_err_q;
  assign sub_word_out  = sub_word_q;
  assign sub_round_out = sub_round_q;

  // Word-chained XOR producing the next round key from the current key and temp.
  always_comb begin
    logic [31:0] w0, w1, w2, w3;
    w0 = key_q[127:96] ^ temp_q;
    w1 = key_q[95:64]  ^ w0;
    w2 = key_q[63:32]  ^ w1;
    w3 = key_q[31:0]   ^ w2;
    key_mix = {w0, w1, w2, w3};
  end

  // Controller FSM plus key/temp/rcon/S-box port registers.
  // The S-box port registers are loaded on entry to SUB so they are stable for
  // the whole SUB cycle and otherwise hold their value to avoid toggling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_q       <= '0;
      temp_q      <= '0;
      idx_q       <= '0;
      rcon_q      <= '0;
      tag_err_q   <= 1'b0;
      sub_word_q  <= '0;
      sub_round_q <= '0;
    end else if (abort_req) begin
      state       <= IDLE;
      idx_q       <= '0;
      rcon_q      <= '0;
      sub_word_q  <= '0;
      sub_round_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key_q  <= key_in;
            idx_q  <= '0;
            rcon_q <= 8'h01;
            state  <= EMIT;
          end
        end
        EMIT: begin
          if (rk_hs) begin
            if (idx_last) begin
              sub_word_q  <= '0;
              sub_round_q <= '0;
              state       <= IDLE;
            end else begin
              sub_word_q  <= rot_word(key_q[31:0]);
              sub_round_q <= idx_q + 4'd1;
              state       <= SUB;
            end
          end
        end
        SUB: begin
          temp_q    <= sub_word_in ^ {rcon_q, 24'h0};
          tag_err_q <= tag_err_q | (sub_round_in != sub_round_q);
          state     <= MIX;
        end
        MIX: begin
          key_q  <= key_mix;
          idx_q  <= idx_q + 4'd1;
          rcon_q <= xtime(rcon_q);
          state  <= EMIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl: self-checking bench for key_expand_ctrl with an
// AES S-box model on the SubWord port and a round-key scoreboard.
module tb_key_expand_ctrl;

  localparam int NR = 10;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  typedef struct packed {
    logic [127:0] rk;
    logic [3:0]   idx;
  } rk_t;

  logic         clk, rst, start, start1, rk_ready;
  logic [127:0] key_in;
  logic         ready_out, rk_valid, rk_last, tag_err;
  logic [31:0]  sub_word_out, sub_word_in;
  logic [3:0]   sub_round_out, sub_round_in, rk_idx;
  logic [127:0] rk_out;
  logic [3:0]   corrupt_round;
  logic         abort;

  logic         ready_out1, rk_valid1, rk_last1, tag_err1;
  logic [31:0]  sub_word_out1, sub_word_in1;
  logic [3:0]   sub_round_out1, sub_round_in1, rk_idx1;
  logic [127:0] rk_out1;

  int checks = 0;
  int errors = 0;
  rk_t sb_q[$];
  rk_t sb_q1[$];

  key_expand_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .start(start),
`ifdef KEY_EXPAND_ABORT_EN
    .abort(abort),
`endif
    .ready_out(ready_out), .sub_word_out(sub_word_out), .sub_round_out(sub_round_out),
    .sub_word_in(sub_word_in), .sub_round_in(sub_round_in), .rk_out(rk_out),
    .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last),
    .tag_err(tag_err)
  );

  key_expand_ctrl #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .key_in(key_in), .start(start1),
`ifdef KEY_EXPAND_ABORT_EN
    .abort(1'b0),
`endif
    .ready_out(ready_out1), .sub_word_out(sub_word_out1), .sub_round_out(sub_round_out1),
    .sub_word_in(sub_word_in1), .sub_round_in(sub_round_in1), .rk_out(rk_out1),
    .rk_idx(rk_idx1), .rk_valid(rk_valid1), .rk_ready(1'b1), .rk_last(rk_last1),
    .tag_err(tag_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) product modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // AES S-box from the field inverse and the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gf_mul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // External SubWord unit models; the main one can return a wrong round tag.
  always_comb begin
    sub_word_in  = sub_word(sub_word_out);
    sub_round_in = sub_round_out;
    if (corrupt_round != 4'd0 && sub_round_out == corrupt_round)
      sub_round_in = sub_round_out + 4'd1;
  end

  always_comb begin
    sub_word_in1  = sub_word(sub_word_out1);
    sub_round_in1 = sub_round_out1;
  end

  // Reference key schedule; pushes rk0..rkN onto a scoreboard queue.
  task automatic push_expected(input logic [127:0] key, input int n, input bit to_q1);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] rc;
    rk_t e;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    e.rk = key; e.idx = 4'd0;
    if (to_q1) sb_q1.push_back(e); else sb_q.push_back(e);
    for (int r = 1; r <= n; r++) begin
      t = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      e.rk = {w0, w1, w2, w3}; e.idx = 4'(r);
      if (to_q1) sb_q1.push_back(e); else sb_q.push_back(e);
      rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
    end
  endtask

  // Pulse start on the main DUT for one cycle; returns at the negedge after acceptance.
  task automatic do_start(input logic [127:0] key);
    key_in = key;
    start = 1'b1;
    push_expected(key, NR, 1'b0);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (ready_out !== 1'b1 || rk_valid !== 1'b0 || tag_err !== 1'b0 || rk_last !== 1'b0 ||
        sub_word_out !== 32'h0 || sub_round_out !== 4'h0 || rk_idx !== 4'h0 || rk_out !== 128'h0)
      begin errors++; $display("FAIL reset: ready=%b valid=%b tag=%b last=%b sw=%h sr=%h idx=%h rk=%h, required 1 0 0 0 0 0 0 0",
        ready_out, rk_valid, tag_err, rk_last, sub_word_out, sub_round_out, rk_idx, rk_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips();
    rk_t e;
    int cyc = 1;
    bit done = 0;
    do_start(FIPS_KEY);
    while (!done && cyc < 100) begin
      rk_ready = 1'b1;
      if (rk_valid && rk_ready) begin
        checks++;
        if (sb_q.size() == 0) begin errors++; $display("FAIL fips_extra: idx=%0d, required none", rk_idx); end
        else begin
          e = sb_q.pop_front();
          if (rk_out !== e.rk || rk_idx !== e.idx || rk_last !== (e.idx == 4'(NR))) begin
            errors++; $display("FAIL fips_rk: idx=%0d rk=%h last=%b, required idx=%0d rk=%h", rk_idx, rk_out, rk_last, e.idx, e.rk);
          end
          if (e.idx == 4'd1) begin
            checks++;
            if (rk_out !== FIPS_RK1) begin errors++; $display("FAIL fips_rk1: %h, required %h", rk_out, FIPS_RK1); end
          end
          if (e.idx == 4'(NR)) begin
            checks++;
            if (rk_out !== FIPS_RK10 || rk_last !== 1'b1) begin errors++; $display("FAIL fips_rk10: %h last=%b, required %h last=1", rk_out, rk_last, FIPS_RK10); end
            checks++;
            if (cyc != 1 + 3 * NR) begin errors++; $display("FAIL fips_latency: %0d, required %0d", cyc, 1 + 3 * NR); end
            done = 1;
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL fips_timeout: last rk not seen, required within 100 cycles"); end
    checks++;
    if (ready_out !== 1'b1 || rk_valid !== 1'b0) begin errors++; $display("FAIL fips_idle: ready=%b valid=%b, required 1 0", ready_out, rk_valid); end
    sb_q.delete();
  endtask

  task automatic test_zero_key();
    rk_t e;
    int cyc = 0;
    do_start(128'h0);
    while (sb_q.size() > 0 && cyc < 100) begin
      rk_ready = 1'b1;
      start = (cyc < 10);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      if (cyc < 10) begin
        checks++;
        if (ready_out !== 1'b0) begin errors++; $display("FAIL busy_ready: %b, required 0", ready_out); end
      end
      if (rk_valid) begin
        e = sb_q.pop_front();
        checks++;
        if (rk_out !== e.rk || rk_idx !== e.idx) begin errors++; $display("FAIL zero_rk: idx=%0d rk=%h, required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk); end
        if (e.idx == 4'd1 || e.idx == 4'(NR)) begin
          checks++;
          if (rk_out !== (e.idx == 4'd1 ? ZERO_RK1 : ZERO_RK10)) begin
            errors++; $display("FAIL zero_const: idx=%0d rk=%h, required %h", e.idx, rk_out, (e.idx == 4'd1 ? ZERO_RK1 : ZERO_RK10));
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL zero_timeout: %0d keys left, required 0", sb_q.size()); end
    sb_q.delete();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    rk_t e;
    int cyc = 0;
    logic [127:0] prev_rk = '0;
    logic [3:0] prev_idx = '0;
    bit prev_stall = 0;
    do_start(FIPS_KEY);
    while (sb_q.size() > 0 && cyc < 400) begin
      if (prev_stall) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== prev_rk || rk_idx !== prev_idx) begin
          errors++; $display("FAIL bp_stable: valid=%b idx=%0d rk=%h, required 1 %0d %h", rk_valid, rk_idx, rk_out, prev_idx, prev_rk);
        end
      end
      rk_ready = 1'($urandom_range(0, 1));
      if (rk_valid && rk_ready) begin
        e = sb_q.pop_front();
        checks++;
        if (rk_out !== e.rk || rk_idx !== e.idx) begin errors++; $display("FAIL bp_rk: idx=%0d rk=%h, required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk); end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk = rk_out;
      prev_idx = rk_idx;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb_q.size() != 0 || rk_valid !== 1'b0) begin errors++; $display("FAIL bp_end: left=%0d valid=%b, required 0 0", sb_q.size(), rk_valid); end
    sb_q.delete();
    rk_ready = 1'b1;
  endtask

  task automatic test_rst_mid();
    rk_t e;
    int cyc = 0;
    bit in_sub = 0;
    rk_ready = 1'b1;
    do_start(FIPS_KEY);
    while (!in_sub && cyc < 100) begin
      if (rk_valid && rk_idx == 4'd4) begin
        e = sb_q[4];
        in_sub = 1;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sub_round_out !== 4'd5 || sub_word_out !== {e.rk[23:0], e.rk[31:24]}) begin
      errors++; $display("FAIL sub_port: round=%0d word=%h, required 5 %h", sub_round_out, sub_word_out, {e.rk[23:0], e.rk[31:24]});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || ready_out !== 1'b1 || rk_idx !== 4'd0) begin
      errors++; $display("FAIL rst_mid: valid=%b ready=%b idx=%0d, required 0 1 0", rk_valid, ready_out, rk_idx);
    end
    sb_q.delete();
    do_start(FIPS_KEY);
    cyc = 0;
    while (sb_q.size() > 0 && cyc < 100) begin
      if (rk_valid) begin
        e = sb_q.pop_front();
        checks++;
        if (rk_out !== e.rk || rk_idx !== e.idx) begin errors++; $display("FAIL rst_restart: idx=%0d rk=%h, required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk); end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL rst_timeout: %0d left, required 0", sb_q.size()); end
    sb_q.delete();
  endtask

  task automatic test_tag_err();
    rk_t e;
    int cyc;
    corrupt_round = 4'd3;
    for (int run = 0; run < 2; run++) begin
      do_start(FIPS_KEY);
      checks++;
      if (tag_err !== 1'(run)) begin errors++; $display("FAIL tag_start: %b, required %0d", tag_err, run); end
      cyc = 0;
      while (sb_q.size() > 0 && cyc < 100) begin
        if (rk_valid) begin
          e = sb_q.pop_front();
          checks++;
          if (rk_out !== e.rk || rk_idx !== e.idx) begin errors++; $display("FAIL tag_rk: idx=%0d rk=%h, required idx=%0d rk=%h", rk_idx, rk_out, e.idx, e.rk); end
        end
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (tag_err !== 1'b1 || sb_q.size() != 0) begin errors++; $display("FAIL tag_end: tag=%b left=%0d, required 1 0", tag_err, sb_q.size()); end
      sb_q.delete();
      corrupt_round = 4'd0;
    end
  endtask

  task automatic test_one_round();
    rk_t e;
    key_in = FIPS_KEY;
    start1 = 1'b1;
    push_expected(FIPS_KEY, 1, 1'b1);
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1 || c == 4) begin
        e = sb_q1.pop_front();
        checks++;
        if (rk_valid1 !== 1'b1 || rk_out1 !== e.rk || rk_idx1 !== e.idx || rk_last1 !== (c == 4)) begin
          errors++; $display("FAIL one_rk: c=%0d valid=%b idx=%0d last=%b rk=%h, required 1 %0d %b %h", c, rk_valid1, rk_idx1, rk_last1, rk_out1, e.idx, (c == 4), e.rk);
        end
      end else begin
        checks++;
        if (rk_valid1 !== 1'b0 || ready_out1 !== (c == 5)) begin
          errors++; $display("FAIL one_gap: c=%0d valid=%b ready=%b, required 0 %b", c, rk_valid1, ready_out1, (c == 5));
        end
      end
      @(negedge clk);
    end
    sb_q1.delete();
  endtask

`ifdef KEY_EXPAND_ABORT_EN
  task automatic test_abort();
    int cyc = 0;
    rk_ready = 1'b1;
    do_start(FIPS_KEY);
    while (!(rk_valid && rk_idx == 4'd4) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (rk_valid !== 1'b0 || ready_out !== 1'b1 || rk_idx !== 4'd0 || sub_round_out !== 4'd0) begin
      errors++; $display("FAIL abort: valid=%b ready=%b idx=%0d sr=%0d, required 0 1 0 0", rk_valid, ready_out, rk_idx, sub_round_out);
    end
    sb_q.delete();
    do_start(ZERO_RK1);
    checks++;
    if (rk_valid !== 1'b1 || rk_out !== ZERO_RK1 || rk_idx !== 4'd0) begin
      errors++; $display("FAIL abort_restart: valid=%b idx=%0d rk=%h, required 1 0 %h", rk_valid, rk_idx, rk_out, ZERO_RK1);
    end
    sb_q.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; start1 = 1'b0; rk_ready = 1'b1;
    key_in = '0; corrupt_round = 4'd0; abort = 1'b0;
    @(negedge clk);
    test_reset();
    test_fips();
    test_zero_key();
    test_backpressure();
    test_rst_mid();
    test_tag_err();
    test_one_round();
`ifdef KEY_EXPAND_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_expand_ctrl.md
Name: key_expand_ctrl

Overview:
- Sequential AES-128 key-schedule controller.
- Accepts a 128-bit cipher key and produces round keys rk0..rkN one at a time on a valid/ready output.
- SubWord is not implemented internally. The block drives the team's shared 4-byte S-box unit (sub_bytes_four) through dedicated ports, one word per round.
- Sits between key load logic and the round-key consumer (cipher core or key RAM writer).

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; legal 1..10; final round index = NUM_ROUNDS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- key_in  input  128  cipher key, word0 = [127:96]; sampled on start handshake.
- start  input  1  request to begin expansion; accepted only when ready_out=1.
- ready_out  output  1  high in IDLE.
- sub_word_out  output  32  RotWord(w3) driven to SubWord unit input.
- sub_round_out  output  4  current round index (1..NUM_ROUNDS) driven to SubWord unit round tag.
- sub_word_in  input  32  SubWord unit result (combinational, same cycle).
- sub_round_in  input  4  round tag returned by SubWord unit; must equal sub_round_out.
- rk_out  output  128  current round key, word0 = [127:96].
- rk_idx  output  4  index of rk_out (0..NUM_ROUNDS).
- rk_valid  output  1  rk_out/rk_idx valid.
- rk_ready  input  1  consumer accepts rk when rk_valid & rk_ready.
- rk_last  output  1  rk_valid & (rk_idx==NUM_ROUNDS).
- tag_err  output  1  sticky; set if sub_round_in != sub_round_out in SUB state.

Behaviour:
- Reset (synchronous, active-high, clk and rst as named above):
  - state=IDLE; key reg, temp reg, rk_idx, round counter, rcon reg = 0.
  - rk_valid=0, tag_err=0, ready_out=1.
  - sub_word_out and sub_round_out = 0 in IDLE.
- State machine:
  - IDLE -> EMIT on start & ready_out. Key reg <= key_in, rk_idx<=0, rcon<=8'h01. start is ignored outside IDLE.
  - EMIT: rk_valid=1, rk_out=key reg; rk_out/rk_idx hold stable while rk_ready=0.
    - On handshake with rk_idx==NUM_ROUNDS -> IDLE.
    - Otherwise -> SUB.
  - SUB (1 cycle):
    - sub_word_out = {w3[23:0], w3[31:24]}; sub_round_out = rk_idx+1.
    - temp <= sub_word_in ^ {rcon, 24'h0}.
    - tag_err <= tag_err | (sub_round_in != rk_idx+1).
    - -> MIX.
  - MIX (1 cycle):
    - w0' = w0^temp; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
    - key reg <= {w0',w1',w2',w3'}; rk_idx <= rk_idx+1; rcon <= xtime(rcon), where xtime = (rcon<<1) ^ (rcon[7] ? 8'h1B : 0), 8-bit.
    - -> EMIT.
- Latency:
  - start accepted at cycle T -> rk0 valid at T+1.
  - rk handshake at cycle t (non-final) -> next rk valid at t+3.
  - Full expansion with rk_ready tied high: 1 + 3*NUM_ROUNDS cycles from start to last handshake.
- Rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.
- sub_word_out and sub_round_out are don't-care outside SUB but are held at the last value (no toggling) for power.
- Boundary conditions:
  - rk_ready low indefinitely: stall in EMIT, no state change.
  - start asserted during expansion: ignored; ready_out=0.
  - rst mid-expansion: immediate return to reset state; rk_valid drops the cycle after rst is sampled; no partial rk emitted.
  - NUM_ROUNDS=1: rk0, rk1, then IDLE.
  - tag_err is cleared only by rst.

Optional Feature:
- Macro KEY_EXPAND_ABORT_EN.
- Defined: adds input abort (1 bit). abort high in any non-IDLE state forces IDLE next cycle, with rk_valid=0 and counters cleared. abort has priority over the rk handshake in the same cycle; abort in IDLE has no effect.
- Undefined: port absent; expansion always runs to completion or rst.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk1=a0fafe1788542cb123a339392a6c7605; rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1; ready_out high 31 cycles after start.
- All-zero key -> rk1=62636363626363636263636362636363; rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready backpressure (about 50% duty) on FIPS key -> identical rk sequence; rk_out stable while rk_valid & !rk_ready; no dropped or duplicated rk_idx.
- rst asserted while in SUB of round 5 -> next cycle rk_valid=0, ready_out=1; a new start with the FIPS key yields the correct full sequence.
- SUB unit model returning a wrong round tag in round 3 -> tag_err=1 and remains 1 through the end of the run; key values are unaffected.
- With KEY_EXPAND_ABORT_EN: abort in EMIT of rk4 with rk_ready=1 -> no handshake counted, IDLE next cycle; restart produces rk0=key_in.
